// File: rtl/service_pkg.sv
// service_pkg: shared types and constants for the front-panel service scheduler.
package service_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, WAIT_FIN, RELEASE} state_e;
  localparam int N_SVC = 4;
  localparam int SEG_W = 16;
  localparam logic [SEG_W-1:0] SEG_BLANK = 16'hFFFF;
endpackage

// File: rtl/push_debouncer.sv
// push_debouncer: synchronizes the raw push button, filters bounce and emits one pulse per accepted press.
module push_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic push_i,
  output logic pulse_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic s1_q, s2_q, level_q, pulse_q, hit;
  logic [CW-1:0] cnt_q, cnt_d;
  // hit marks the DEBOUNCE_CYCLES-th consecutive sample that disagrees with the accepted level
  always_comb begin
    hit = (s2_q != level_q) && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
    cnt_d = (s2_q == level_q || hit) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q <= push_i;
      s2_q <= s1_q;
      level_q <= hit ? s2_q : level_q;
      pulse_q <= hit && s2_q;
      cnt_q <= cnt_d;
    end
  end
  assign pulse_o = pulse_q;
endmodule

// File: rtl/service_scheduler.sv
// service_scheduler: grants one service exclusive use of the push button and display, round-robin on switch-on.
module service_scheduler #(
  parameter int N_SVC = service_pkg::N_SVC,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [N_SVC-1:0]                    spdt,
  input  logic                                push_m,
  input  logic [N_SVC-1:0]                    finish,
  input  logic [service_pkg::SEG_W*N_SVC-1:0] seg_in,
  output logic [N_SVC-1:0]                    grant,
  output logic [N_SVC-1:0]                    push_pulse,
  output logic [service_pkg::SEG_W-1:0]       segments,
  output logic                                conflict,
  output logic                                busy
);
  import service_pkg::*;
  localparam int OW = (N_SVC > 1) ? $clog2(N_SVC) : 1;
  state_e state_q;
  logic [OW-1:0] owner_q, last_q, pick;
  logic [N_SVC-1:0] spdt_s1_q, spdt_s_q, owner_oh, push_pulse_q;
  logic [SEG_W-1:0] segments_q;
  logic conflict_q, push_ev, held, found;
  push_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .clk    (clk),
    .reset  (reset),
    .push_i (push_m),
    .pulse_o(push_ev)
  );
  // first requesting service after the previous owner, wrapping around
  always_comb begin
    pick = owner_q;
    found = 1'b0;
    for (int k = 1; k <= N_SVC; k++) begin
      if (!found && spdt_s_q[(int'(last_q) + k) % N_SVC]) begin
        pick = OW'((int'(last_q) + k) % N_SVC);
        found = 1'b1;
      end
    end
  end
  assign owner_oh = {{(N_SVC-1){1'b0}}, 1'b1} << owner_q;
  assign held = (state_q == GRANT) || (state_q == WAIT_FIN);
  assign grant = held ? owner_oh : '0;
  assign busy = state_q != IDLE;
  assign push_pulse = push_pulse_q;
  assign segments = segments_q;
  assign conflict = conflict_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q <= OW'(N_SVC - 1);
      spdt_s1_q <= '0;
      spdt_s_q <= '0;
      push_pulse_q <= '0;
      segments_q <= SEG_BLANK;
      conflict_q <= 1'b0;
    end else begin
      spdt_s1_q <= spdt;
      spdt_s_q <= spdt_s1_q;
      push_pulse_q <= (state_q == GRANT && push_ev) ? owner_oh : '0;
      segments_q <= held ? seg_in[owner_q*SEG_W +: SEG_W] : SEG_BLANK;
      conflict_q <= held && |(spdt_s_q & ~owner_oh);
      case (state_q)
        IDLE: if (|spdt_s_q) begin
          owner_q <= pick;
          state_q <= GRANT;
        end
        GRANT: if (!spdt_s_q[owner_q]) state_q <= WAIT_FIN;
        WAIT_FIN: state_q <= finish[owner_q] ? RELEASE : spdt_s_q[owner_q] ? GRANT : WAIT_FIN;
        default: begin
          last_q <= owner_q;
          state_q <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_service_scheduler.sv
// tb_service_scheduler: directed table, corner sequences and randomized run against a reference model.
module tb_service_scheduler;
  localparam int DC = 4;
  localparam int FREE = 0, OWNED = 1, SWITCHED_OFF = 2, HANDOVER = 3;
  logic clk = 1'b0, reset = 1'b1, push_m = 1'b0;
  logic [3:0] spdt = '0, finish = '0;
  logic [63:0] seg_in = {16'h4444, 16'h1234, 16'h2222, 16'h1111};
  logic [3:0] grant, push_pulse;
  logic [15:0] segments;
  logic conflict, busy;
  int checks = 0, errors = 0, pulses = 0;
  logic [3:0] last_pulse = '0;
  bit mon_en = 1'b0;
  logic [3:0] m_sp1, m_sp2, m_pulse;
  logic m_p1, m_p2, m_acc, m_ev, m_conf;
  logic [15:0] m_seg;
  int m_run, m_phase, m_owner, m_last;

  service_scheduler #(.N_SVC(4), .DEBOUNCE_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .spdt(spdt), .push_m(push_m), .finish(finish), .seg_in(seg_in),
    .grant(grant), .push_pulse(push_pulse), .segments(segments), .conflict(conflict), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] sw, fin;
    int cyc;
    logic [3:0] g;
    logic [15:0] seg;
    logic b, c;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t v(logic [3:0] sw, logic [3:0] fin, int cyc, logic [3:0] g, logic [15:0] seg, logic b, logic c);
    vec_t r;
    r.sw = sw; r.fin = fin; r.cyc = cyc; r.g = g; r.seg = seg; r.b = b; r.c = c;
    return r;
  endfunction

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: inputs seen two edges late, a press accepted after DC consecutive disagreeing samples,
  // ownership rules applied on the synchronized view of the switches.
  task automatic model_step();
    bit held;
    if (reset) begin
      m_sp1 = '0; m_sp2 = '0; m_p1 = 0; m_p2 = 0; m_acc = 0; m_ev = 0; m_run = 0;
      m_phase = FREE; m_owner = 0; m_last = 3; m_seg = 16'hFFFF; m_conf = 0; m_pulse = '0;
    end else begin
      held = (m_phase == OWNED) || (m_phase == SWITCHED_OFF);
      m_pulse = (m_phase == OWNED && m_ev) ? 4'(1 << m_owner) : 4'b0;
      m_seg = held ? seg_in[m_owner*16 +: 16] : 16'hFFFF;
      m_conf = held && ((m_sp2 & ~4'(1 << m_owner)) != 0);
      case (m_phase)
        FREE: if (m_sp2 != 0) begin
          for (int k = 1; k <= 4; k++) begin
            if (m_sp2[(m_last + k) % 4]) begin
              m_owner = (m_last + k) % 4;
              break;
            end
          end
          m_phase = OWNED;
        end
        OWNED: if (!m_sp2[m_owner]) m_phase = SWITCHED_OFF;
        SWITCHED_OFF: if (finish[m_owner]) m_phase = HANDOVER; else if (m_sp2[m_owner]) m_phase = OWNED;
        default: begin m_last = m_owner; m_phase = FREE; end
      endcase
      m_run = (m_p2 != m_acc) ? m_run + 1 : 0;
      m_ev = 0;
      if (m_run == DC) begin
        m_acc = m_p2;
        m_run = 0;
        m_ev = m_acc;
      end
      m_p2 = m_p1; m_p1 = push_m; m_sp2 = m_sp1; m_sp1 = spdt;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (mon_en) begin
      chk("m_grant", 16'(grant), 16'((m_phase == OWNED || m_phase == SWITCHED_OFF) ? 4'(1 << m_owner) : 4'b0));
      chk("m_busy", 16'(busy), 16'(m_phase != FREE));
      chk("m_segments", segments, m_seg);
      chk("m_conflict", 16'(conflict), 16'(m_conf));
      chk("m_push_pulse", 16'(push_pulse), 16'(m_pulse));
    end
    if (push_pulse != 0) begin
      pulses++;
      last_pulse = push_pulse;
    end
  endtask

  task automatic press(int hi, int lo);
    push_m = 1'b1;
    repeat (hi) tick();
    push_m = 1'b0;
    repeat (lo) tick();
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_grant", 16'(grant), 16'h0);
    chk("rst_segments", segments, 16'hFFFF);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_conflict", 16'(conflict), 16'h0);
    chk("rst_push_pulse", 16'(push_pulse), 16'h0);
    reset = 1'b0;
    mon_en = 1'b1;
    tbl.push_back(v(4'b0100, 4'b0000, 1, 4'b0000, 16'hFFFF, 0, 0));
    tbl.push_back(v(4'b0100, 4'b0000, 1, 4'b0000, 16'hFFFF, 0, 0));
    tbl.push_back(v(4'b0100, 4'b0000, 1, 4'b0100, 16'hFFFF, 1, 0));
    tbl.push_back(v(4'b0100, 4'b0000, 1, 4'b0100, 16'h1234, 1, 0));
    tbl.push_back(v(4'b0101, 4'b0000, 3, 4'b0100, 16'h1234, 1, 1));
    tbl.push_back(v(4'b0001, 4'b0000, 3, 4'b0100, 16'h1234, 1, 1));
    tbl.push_back(v(4'b0001, 4'b0000, 2, 4'b0100, 16'h1234, 1, 1));
    tbl.push_back(v(4'b0001, 4'b0100, 1, 4'b0000, 16'h1234, 1, 1));
    tbl.push_back(v(4'b0001, 4'b0000, 1, 4'b0000, 16'hFFFF, 0, 0));
    tbl.push_back(v(4'b0001, 4'b0000, 1, 4'b0001, 16'hFFFF, 1, 0));
    tbl.push_back(v(4'b0001, 4'b0000, 1, 4'b0001, 16'h1111, 1, 0));
    tbl.push_back(v(4'b0000, 4'b0000, 3, 4'b0001, 16'h1111, 1, 0));
    tbl.push_back(v(4'b0000, 4'b0001, 1, 4'b0000, 16'h1111, 1, 0));
    tbl.push_back(v(4'b1011, 4'b0000, 1, 4'b0000, 16'hFFFF, 0, 0));
    tbl.push_back(v(4'b1011, 4'b0000, 2, 4'b0010, 16'hFFFF, 1, 0));
    tbl.push_back(v(4'b1011, 4'b0000, 1, 4'b0010, 16'h2222, 1, 1));
    tbl.push_back(v(4'b1001, 4'b0000, 3, 4'b0010, 16'h2222, 1, 1));
    tbl.push_back(v(4'b1001, 4'b0010, 1, 4'b0000, 16'h2222, 1, 1));
    tbl.push_back(v(4'b1001, 4'b0000, 1, 4'b0000, 16'hFFFF, 0, 0));
    tbl.push_back(v(4'b1001, 4'b0000, 1, 4'b1000, 16'hFFFF, 1, 0));
    tbl.push_back(v(4'b1001, 4'b0000, 1, 4'b1000, 16'h4444, 1, 1));
    tbl.push_back(v(4'b0001, 4'b0000, 3, 4'b1000, 16'h4444, 1, 1));
    tbl.push_back(v(4'b0001, 4'b1000, 1, 4'b0000, 16'h4444, 1, 1));
    tbl.push_back(v(4'b0001, 4'b0000, 2, 4'b0001, 16'hFFFF, 1, 0));
    foreach (tbl[i]) begin
      spdt = tbl[i].sw;
      finish = tbl[i].fin;
      repeat (tbl[i].cyc) tick();
      chk($sformatf("row%0d_grant", i), 16'(grant), 16'(tbl[i].g));
      chk($sformatf("row%0d_segments", i), segments, tbl[i].seg);
      chk($sformatf("row%0d_busy", i), 16'(busy), 16'(tbl[i].b));
      chk($sformatf("row%0d_conflict", i), 16'(conflict), 16'(tbl[i].c));
    end
    finish = '0;
    pulses = 0;
    press(10, 12);
    chk("push_once", 16'(pulses), 16'd1);
    chk("push_owner", 16'(last_pulse), 16'b0001);
    pulses = 0;
    press(3, 1);
    press(3, 12);
    chk("bounce_none", 16'(pulses), 16'd0);
    press(6, 12);
    chk("stable_six", 16'(pulses), 16'd1);
    spdt = '0;
    repeat (4) tick();
    finish = 4'b0001;
    tick();
    finish = '0;
    for (int n = 0; n < 10 && busy; n++) tick();
    chk("idle_reached", 16'(busy), 16'd0);
    pulses = 0;
    press(10, 12);
    spdt = 4'b0100;
    repeat (12) tick();
    chk("idle_press_dropped", 16'(pulses), 16'd0);
    chk("idle_then_grant2", 16'(grant), 16'b0100);
    spdt = '0;
    repeat (4) tick();
    chk("midop_wait_fin", 16'(grant), 16'b0100);
    push_m = 1'b1;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    chk("midrst_grant", 16'(grant), 16'h0);
    chk("midrst_segments", segments, 16'hFFFF);
    chk("midrst_busy", 16'(busy), 16'h0);
    chk("midrst_conflict", 16'(conflict), 16'h0);
    chk("midrst_push_pulse", 16'(push_pulse), 16'h0);
    reset = 1'b0;
    push_m = 1'b0;
    pulses = 0;
    spdt = 4'b1111;
    repeat (3) tick();
    chk("post_rst_grant0", 16'(grant), 16'b0001);
    repeat (10) tick();
    chk("post_rst_no_pulse", 16'(pulses), 16'd0);
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 699) == 0);
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 29) == 0) spdt[b] = ~spdt[b];
        finish[b] = ($urandom_range(0, 4) == 0);
      end
      if ($urandom_range(0, 4) == 0) push_m = ~push_m;
      if ($urandom_range(0, 99) == 0) seg_in = {$urandom, $urandom};
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
